// File: rtl/icache_if.sv
// Fetcher and refill-bus signals of the instruction cache, grouped for the cache port.
// Refill handshake: mem_req is a level held for a whole line; mem_valid is a one-cycle pulse answering mem_addr.
interface icache_if;
   logic        icache_enable;
   logic [31:0] pc_to_icache;
   logic        icache_valid;
   logic [31:0] icache_inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;

   modport master (
      output icache_enable, pc_to_icache, mem_valid, mem_data,
      input  icache_valid, icache_inst, mem_req, mem_addr
   );

   modport slave (
      input  icache_enable, pc_to_icache, mem_valid, mem_data,
      output icache_valid, icache_inst, mem_req, mem_addr
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, line refill
// one word per memory handshake, never aborted by a pc change.
module icache #(
   parameter int INDEX_BITS = 4,
   parameter int WORD_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   icache_if.slave              bus,
   output logic                 dbg_state,
   output logic [WORD_BITS-1:0] dbg_cnt
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << WORD_BITS;
   localparam int IDX_LSB  = WORD_BITS + 2;
   localparam int TAG_LSB  = INDEX_BITS + WORD_BITS + 2;
   localparam int TAG_BITS = 32 - TAG_LSB;
   localparam logic [WORD_BITS-1:0] LAST = WORD_BITS'(WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                 state, state_nxt;
   logic [WORD_BITS-1:0]   cnt, cnt_nxt;
   logic                   req_q, req_nxt;
   logic [31:0]            addr_q, addr_nxt;
   logic                   start_fill, word_we, line_done;

   logic [LINES-1:0]       valid_q;
   logic [TAG_BITS-1:0]    tag_mem  [LINES];
   logic [31:0]            data_mem [LINES][WORDS];

   logic [WORD_BITS-1:0]   pc_off;
   logic [INDEX_BITS-1:0]  pc_idx, fill_idx;
   logic [TAG_BITS-1:0]    pc_tag, fill_tag;
   logic                   hit;
   logic                   unused_bits;

   assign pc_off      = bus.pc_to_icache[IDX_LSB-1:2];
   assign pc_idx      = bus.pc_to_icache[TAG_LSB-1:IDX_LSB];
   assign pc_tag      = bus.pc_to_icache[31:TAG_LSB];
   assign unused_bits = ^bus.pc_to_icache[1:0];

   // mem_addr only walks the offset bits, so it carries the fill line's index and tag.
   assign fill_idx = addr_q[TAG_LSB-1:IDX_LSB];
   assign fill_tag = addr_q[31:TAG_LSB];

   assign hit              = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign bus.icache_valid = bus.icache_enable && hit;
   assign bus.icache_inst  = data_mem[pc_idx][pc_off];
   assign bus.mem_req      = req_q;
   assign bus.mem_addr     = addr_q;
   assign dbg_state        = (state == FILL);
   assign dbg_cnt          = cnt;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_nxt    = req_q;
      addr_nxt   = addr_q;
      start_fill = 1'b0;
      word_we    = 1'b0;
      line_done  = 1'b0;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (bus.icache_enable && !hit) begin
                  start_fill = 1'b1;
                  cnt_nxt    = '0;
                  req_nxt    = 1'b1;
                  addr_nxt   = {bus.pc_to_icache[31:IDX_LSB], {IDX_LSB{1'b0}}};
                  state_nxt  = FILL;
               end
            end
            FILL: begin
               if (bus.mem_valid) begin
                  word_we = 1'b1;
                  if (cnt == LAST) begin
                     line_done = 1'b1;
                     req_nxt   = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     cnt_nxt  = cnt + WORD_BITS'(1);
                     addr_nxt = addr_q + 32'd4;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         req_q  <= req_nxt;
         addr_q <= addr_nxt;
         // The line being refilled stays invalid so partial lines never hit.
         if (start_fill) valid_q[pc_idx]  <= 1'b0;
         if (line_done)  valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_done) tag_mem[fill_idx]       <= fill_tag;
      if (word_we)   data_mem[fill_idx][cnt] <= bus.mem_data;
   end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: hand-driven refill bus, a vector table of lookups,
// and hand-written sequences for the multi-cycle corner cases.
module tb_icache;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rdy = 1'b1;
   logic       dbg_state;
   logic [1:0] dbg_cnt;
   int         n_total = 0;
   int         n_pass  = 0;

   icache_if bus();

   icache dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .bus       (bus.slave),
      .dbg_state (dbg_state),
      .dbg_cnt   (dbg_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        en;
      logic [31:0] pc;
      logic        exp_valid;
      logic        chk_inst;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs[10];

   // Backing memory contents: a simple function of the word address.
   function automatic logic [31:0] mw(input logic [31:0] a);
      return 32'hA0 + (a >> 2);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   task automatic start_miss(input logic [31:0] pc, input string nm);
      @(negedge clk);
      bus.icache_enable = 1'b1;
      bus.pc_to_icache  = pc;
      #1;
      check({nm, " miss valid"}, 32'(bus.icache_valid), 32'd0);
      check({nm, " req before"}, 32'(bus.mem_req), 32'd0);
   endtask

   task automatic serve_word(input logic [31:0] base, input int w, input int lat);
      logic [31:0] a;
      a = base + 32'(4 * w);
      repeat (lat) @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("req %h", a), 32'(bus.mem_req), 32'd1);
      check($sformatf("addr %h", a), bus.mem_addr, a);
      bus.mem_valid = 1'b1;
      bus.mem_data  = mw(a);
      @(negedge clk);
      bus.mem_valid = 1'b0;
   endtask

   task automatic serve_line(input logic [31:0] base, input int lat);
      for (int w = 0; w < 4; w++) serve_word(base, w, lat);
   endtask

   task automatic expect_hit(input string nm, input logic [31:0] pc);
      bus.pc_to_icache = pc;
      #1;
      check({nm, " valid"}, 32'(bus.icache_valid), 32'd1);
      check({nm, " inst"}, bus.icache_inst, mw(pc & 32'hFFFF_FFFC));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"t hit w0",     1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'hA0};
      vecs[1] = '{"t hit w2",     1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'hA2};
      vecs[2] = '{"t hit 8c",     1'b1, 32'h0000_008C, 1'b1, 1'b1, 32'hC3};
      vecs[3] = '{"t hit c8",     1'b1, 32'h0000_00C8, 1'b1, 1'b1, 32'hD2};
      vecs[4] = '{"t en low",     1'b0, 32'h0000_0004, 1'b0, 1'b1, 32'hA1};
      vecs[5] = '{"t tag diff",   1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{"t cold line",  1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{"t byte bits",  1'b1, 32'h0000_0002, 1'b1, 1'b1, 32'hA0};
      vecs[8] = '{"t byte w3",    1'b1, 32'h0000_008F, 1'b1, 1'b1, 32'hC3};
      vecs[9] = '{"t high tag",   1'b1, 32'h0000_1080, 1'b0, 1'b0, 32'h0};

      bus.icache_enable = 1'b1;
      bus.pc_to_icache  = 32'h0;
      bus.mem_valid     = 1'b0;
      bus.mem_data      = 32'h0;

      // Reset state
      #1;
      check("rst req", 32'(bus.mem_req), 32'd0);
      check("rst addr", bus.mem_addr, 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      check("rst cnt", 32'(dbg_cnt), 32'd0);
      check("rst valid", 32'(bus.icache_valid), 32'd0);
      bus.icache_enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Cold miss on line 0x0
      start_miss(32'h0, "cold");
      serve_line(32'h0, 1);
      #1;
      check("cold req done", 32'(bus.mem_req), 32'd0);
      check("cold state", 32'(dbg_state), 32'd0);
      expect_hit("cold 0x0", 32'h0);
      expect_hit("cold 0xc", 32'hC);
      bus.icache_enable = 1'b0;

      // Hit on another line while 0x80 is filling
      start_miss(32'h80, "hf");
      serve_word(32'h80, 0, 0);
      expect_hit("hf 0x4", 32'h4);
      bus.pc_to_icache = 32'h84;
      #1;
      check("hf partial0", 32'(bus.icache_valid), 32'd0);
      serve_word(32'h80, 1, 2);
      serve_word(32'h80, 2, 0);
      #1;
      check("hf partial2", 32'(bus.icache_valid), 32'd0);
      serve_word(32'h80, 3, 0);
      #1;
      check("hf req done", 32'(bus.mem_req), 32'd0);
      expect_hit("hf 0x84", 32'h84);
      bus.icache_enable = 1'b0;

      // rdy low mid-fill freezes the fill even with mem_valid pulses
      start_miss(32'hC0, "rdy");
      serve_word(32'hC0, 0, 0);
      rdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bus.mem_valid = 1'b1;
         bus.mem_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      bus.mem_valid = 1'b0;
      #1;
      check("rdy cnt", 32'(dbg_cnt), 32'd1);
      check("rdy addr", bus.mem_addr, 32'hC4);
      check("rdy req", 32'(bus.mem_req), 32'd1);
      check("rdy state", 32'(dbg_state), 32'd1);
      rdy = 1'b1;
      for (int w = 1; w < 4; w++) serve_word(32'hC0, w, 0);
      expect_hit("rdy 0xc4", 32'hC4);
      bus.icache_enable = 1'b0;

      // rdy low in IDLE: a miss does not start a fill
      @(negedge clk);
      rdy = 1'b0;
      bus.icache_enable = 1'b1;
      bus.pc_to_icache  = 32'h500;
      repeat (2) @(negedge clk);
      #1;
      check("idle rdy req", 32'(bus.mem_req), 32'd0);
      check("idle rdy state", 32'(dbg_state), 32'd0);

      // Lookup table, rdy held low so misses cannot start fills
      for (int i = 0; i < 10; i++) begin
         bus.icache_enable = vecs[i].en;
         bus.pc_to_icache  = vecs[i].pc;
         #1;
         check({vecs[i].nm, " valid"}, 32'(bus.icache_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].chk_inst)
            check({vecs[i].nm, " inst"}, bus.icache_inst, vecs[i].exp_inst);
      end
      bus.icache_enable = 1'b0;
      @(negedge clk);
      rdy = 1'b1;
      #1;
      check("table req", 32'(bus.mem_req), 32'd0);

      // Redirect mid-fill: 0x40 completes, then 0x200 is fetched
      start_miss(32'h40, "rd");
      serve_word(32'h40, 0, 0);
      bus.pc_to_icache = 32'h200;
      for (int w = 1; w < 4; w++) serve_word(32'h40, w, 1);
      #1;
      check("rd req gap", 32'(bus.mem_req), 32'd0);
      check("rd 0x200 miss", 32'(bus.icache_valid), 32'd0);
      serve_line(32'h200, 0);
      expect_hit("rd 0x200", 32'h200);
      expect_hit("rd 0x44", 32'h44);
      bus.icache_enable = 1'b0;

      // Conflict eviction on index 0
      start_miss(32'h0, "cf0");
      serve_line(32'h0, 0);
      expect_hit("cf 0x0", 32'h0);
      start_miss(32'h100, "cf1");
      serve_line(32'h100, 0);
      expect_hit("cf 0x108", 32'h108);
      start_miss(32'h0, "cf2");
      serve_line(32'h0, 0);
      expect_hit("cf 0x0 again", 32'h0);
      bus.icache_enable = 1'b0;

      // Asynchronous reset mid-fill
      start_miss(32'h1C0, "ar");
      serve_word(32'h1C0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check("ar req", 32'(bus.mem_req), 32'd0);
      check("ar state", 32'(dbg_state), 32'd0);
      check("ar addr", bus.mem_addr, 32'd0);
      check("ar cnt", 32'(dbg_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.pc_to_icache = 32'h0;
      #1;
      check("ar 0x0 miss", 32'(bus.icache_valid), 32'd0);
      bus.icache_enable = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that services the instruction fetcher's `pc_to_icache` / `icache_enable` request. It returns `icache_valid` / `icache_inst` combinationally on a hit. On a miss it refills a full line from the memory controller, one word per handshake. The fetcher samples `icache_valid` / `icache_inst` at the same posedge it advances `pc`, so hit data always corresponds to the current `pc`.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width (16 lines).
- `WORD_BITS`, 2: log2 of words per line (4 words, 16 bytes per line).

Ports:
- `clk`  in  1: clock; all state changes on posedge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: global ready; when low, all state freezes and `mem_valid` is ignored.
- `icache_enable`  in  1: fetcher requests the instruction at `pc_to_icache`.
- `pc_to_icache`  in  32: fetch byte address; bits [1:0] are ignored.
- `icache_valid`  out  1: hit; `icache_inst` holds the instruction at `pc_to_icache`. Combinational.
- `icache_inst`  out  32: instruction word from the data array. Combinational.
- `mem_req`  out  1: refill word request (level). Registered.
- `mem_addr`  out  32: word-aligned refill address, stable while `mem_req` is high. Registered.
- `mem_valid`  in  1: one-cycle pulse; `mem_data` answers the current `mem_addr`.
- `mem_data`  in  32: refill word.

## Operation
- Address split: word offset = `pc[WORD_BITS+1:2]`; index = `pc[INDEX_BITS+WORD_BITS+1:WORD_BITS+2]`; tag = the remaining upper bits (24 bits at defaults).
- Storage per line: valid bit, tag, and 2^WORD_BITS data words. All arrays are register-based with asynchronous read.
- hit = `valid[index]` && `tag[index]` == pc tag. `icache_valid` = `icache_enable` && hit. `icache_inst` = `data[index][offset]` unconditionally.
- State machine, states IDLE and FILL:
  - **IDLE.** If `rdy` && `icache_enable` && !hit:
    - latch `fill_base` = pc with offset and byte bits cleared;
    - clear `valid[index]`;
    - set `cnt` = 0, `mem_req` = 1, `mem_addr` = `fill_base`;
    - go to FILL.
  - **FILL.** On `rdy` && `mem_valid`:
    - write `mem_data` to `data[fill_index][cnt]`.
    - If `cnt` is not the last word: `cnt` += 1, `mem_addr` += 4, `mem_req` stays 1.
    - If `cnt` == 2^WORD_BITS−1: set `valid[fill_index]` = 1, write `tag[fill_index]` = fill tag, `mem_req` = 0, go to IDLE.
- Hits are served in both states. The line being filled has its valid bit clear, so partial lines never hit.
- A refill is never aborted by a `pc` change (jalr redirect, rollback). The line completes; the new `pc` is then evaluated in IDLE.
- `cnt` is WORD_BITS wide; `mem_addr` increments stay inside the line (no carry into index/tag by construction).

## Timing
- Reset (`rst` low, asynchronous): state = IDLE, all valid bits = 0, `mem_req` = 0, `mem_addr` = 0, `cnt` = 0. `icache_valid` is therefore 0. Tags and data are don't-care.
- Reset mid-FILL: the refill is abandoned immediately and `mem_req` drops asynchronously. The memory controller is reset by the same `rst`.
- Hit latency: 0 cycles (same cycle as the request).
- Miss penalty:
  - `mem_req` rises one cycle after the missing request is first seen.
  - Each word costs whatever latency the memory controller takes.
  - The edge that consumes the last `mem_valid` sets the valid bit and returns to IDLE.
  - `icache_valid` rises in the following cycle (combinational, if `pc` is unchanged).
- Handshake: `mem_req` stays high across the whole line. `mem_addr` updates on the edge that consumes `mem_valid`. The controller samples the new address from the next cycle. A `mem_valid` seen while `mem_req` = 0 is ignored.
- `rdy` low: no state, array, or output-register change. Combinational outputs still track their inputs.
- `icache_enable` low: no miss is started. `icache_valid` = 0. An in-progress FILL continues.

## Test plan
- **Cold miss.** After reset, enable with pc = 0x0. Memory returns 0xA0, 0xA1, 0xA2, 0xA3 for 0x0, 0x4, 0x8, 0xC. Required: `mem_req` = 1 one cycle later with addr 0x0, stepping through 0x4, 0x8, 0xC. `icache_valid` = 1 with inst 0xA0 the cycle after the 4th `mem_valid`. pc = 0xC then hits immediately with 0xA3.
- **Conflict eviction.** Fill line 0x0, then request pc = 0x100 (index 0, tag 1). Required: miss, refill from 0x100 through 0x10C. A later pc = 0x0 misses again.
- **Redirect mid-fill.** During a fill of 0x40, pc changes to 0x200. Required: fill of 0x40 through 0x4C completes. Next cycle `mem_req` restarts with `mem_addr` = 0x200. pc = 0x44 later hits.
- **Hit during fill.** Line 0x0 is valid, then a fill of 0x80 runs. Required: pc = 0x4 gives `icache_valid` = 1 mid-fill. pc = 0x84 gives `icache_valid` = 0 until that fill completes.
- **rdy and enable gating.** Hold `rdy` = 0 for 3 cycles mid-fill while pulsing `mem_valid`. Required: `cnt` and `mem_addr` unchanged. Enable = 0 on a hit address gives `icache_valid` = 0.
- **Async reset mid-fill.** Assert `rst` low between edges during FILL. Required: `mem_req` = 0 immediately. After release, the previously valid pc = 0x0 misses.
